// File: rtl/mc_load_sequencer_if.sv
// Purpose : bundles the run/duty command inputs, the comparator input and the
//           load/sign/status outputs of the matrix-converter load sequencer.
// Latency : wires only.
// Backpressure: none; duty_load is a one-cycle strobe with no ready return.
// Ports   : master drives enable, fault, duty_load, duty_a, duty_b, period and
//           current_cmp, and observes DesiredLoad, CurrentSign, period_start,
//           duty_err and running. The slave modport is the reverse view.
interface mc_load_sequencer_if #(
    parameter int PW = 10
);
    logic          enable;
    logic          fault;
    logic          duty_load;
    logic [PW-1:0] duty_a;
    logic [PW-1:0] duty_b;
    logic [PW-1:0] period;
    logic          current_cmp;
    logic [1:0]    DesiredLoad;
    logic          CurrentSign;
    logic          period_start;
    logic          duty_err;
    logic          running;

    modport master (
        output enable, fault, duty_load, duty_a, duty_b, period, current_cmp,
        input  DesiredLoad, CurrentSign, period_start, duty_err, running
    );

    modport slave (
        input  enable, fault, duty_load, duty_a, duty_b, period, current_cmp,
        output DesiredLoad, CurrentSign, period_start, duty_err, running
    );
endinterface

// File: rtl/mc_load_sequencer.sv
// Purpose : walks each carrier period through source phases A, B, C for the
//           commutation FSM, and debounces the current-direction comparator.
// Latency : DesiredLoad shows the segment of counter value n one clock after n;
//           CurrentSign follows a stable comparator change after DEB+2 clocks.
// Backpressure: none. Loads are always accepted or rejected in one clock;
//           fault stops the sequence on the next clock.
// Ports   : clk, rst (async active-low), bus (slave view of mc_load_sequencer_if).
module mc_load_sequencer #(
    parameter int PW        = 10,
    parameter int MIN_DWELL = 12,
    parameter int DEB       = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    mc_load_sequencer_if.slave    bus
);
    localparam logic [0:0]    ST_IDLE = 1'b0;
    localparam logic [0:0]    ST_RUN  = 1'b1;
    localparam logic [PW-1:0] MIN_D   = PW'(MIN_DWELL);
    localparam int            CW      = $clog2(DEB + 1);
    localparam logic [CW-1:0] DEB_LAST = CW'(DEB - 1);

    // A segment shorter than the commutation time cannot be realised, so it
    // is dropped rather than stretched.
    function automatic logic [PW-1:0] clip(input logic [PW-1:0] d);
        return ((d != '0) && (d < MIN_D)) ? '0 : d;
    endfunction

    logic [0:0]    state;
    logic [PW-1:0] cnt;
    logic [PW-1:0] act_a, act_b, act_p;
    logic [PW-1:0] pend_a, pend_b, pend_p;
    logic          act_vld, pend_vld;
    logic [1:0]    dl;
    logic          ps;
    logic          err;

    logic [PW-1:0] ld_a, ld_b;
    logic [PW:0]   ld_sum;
    logic          ld_ok;
    logic [PW:0]   act_sum, rem, end_a, end_b, cnt_x;
    logic [1:0]    seg;
    logic          boundary;
    logic          start;

    always_comb begin
        ld_a   = clip(bus.duty_a);
        ld_b   = clip(bus.duty_b);
        ld_sum = {1'b0, ld_a} + {1'b0, ld_b};
        ld_ok  = (bus.period >= MIN_D) && (ld_sum <= {1'b0, bus.period});

        // Segment end points for the active set. A short phase-C remainder
        // is folded into the last non-zero segment so C is never emitted
        // for less than a full commutation.
        act_sum = {1'b0, act_a} + {1'b0, act_b};
        rem     = {1'b0, act_p} - act_sum;
        end_a   = {1'b0, act_a};
        end_b   = act_sum;
        if ((rem != '0) && (rem < {1'b0, MIN_D})) begin
            end_b = {1'b0, act_p};
            if (act_b == '0) begin
                end_a = {1'b0, act_p};
            end
        end

        cnt_x = {1'b0, cnt};
        if (cnt_x < end_a) begin
            seg = 2'b01;
        end else if (cnt_x < end_b) begin
            seg = 2'b10;
        end else begin
            seg = 2'b11;
        end

        boundary = (cnt == (act_p - PW'(1)));
        start    = (state == ST_IDLE) && bus.enable && (pend_vld || act_vld);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            act_a    <= '0;
            act_b    <= '0;
            act_p    <= '0;
            act_vld  <= 1'b0;
            pend_a   <= '0;
            pend_b   <= '0;
            pend_p   <= '0;
            pend_vld <= 1'b0;
            dl       <= 2'b00;
            ps       <= 1'b0;
            err      <= 1'b0;
        end else begin
            ps <= 1'b0;
            if (bus.fault) begin
                // Fault wins over everything, including a same-clock load.
                state <= ST_IDLE;
                cnt   <= '0;
                dl    <= 2'b00;
            end else begin
                if (state == ST_IDLE) begin
                    if (start) begin
                        state <= ST_RUN;
                        cnt   <= '0;
                        ps    <= 1'b1;
                        if (pend_vld) begin
                            act_a    <= pend_a;
                            act_b    <= pend_b;
                            act_p    <= pend_p;
                            act_vld  <= 1'b1;
                            pend_vld <= 1'b0;
                        end
                    end
                end else begin
                    if (boundary) begin
                        cnt <= '0;
                        if (pend_vld) begin
                            act_a    <= pend_a;
                            act_b    <= pend_b;
                            act_p    <= pend_p;
                            act_vld  <= 1'b1;
                            pend_vld <= 1'b0;
                        end
                        if (!bus.enable) begin
                            state <= ST_IDLE;
                            dl    <= 2'b00;
                        end else begin
                            ps <= 1'b1;
                            dl <= seg;
                        end
                    end else begin
                        cnt <= cnt + PW'(1);
                        dl  <= seg;
                    end
                end

                // Placed after the promotion so a load coinciding with a
                // period boundary survives as the next pending set.
                if (bus.duty_load) begin
                    if (ld_ok) begin
                        pend_a   <= ld_a;
                        pend_b   <= ld_b;
                        pend_p   <= bus.period;
                        pend_vld <= 1'b1;
                        err      <= 1'b0;
                    end else begin
                        err <= 1'b1;
                    end
                end
            end
        end
    end

    // Current-sign conditioning: two-flop synchronizer, then a run-length
    // counter of samples disagreeing with the present sign.
    logic          sync1, sync2;
    logic          sign;
    logic [CW-1:0] dcnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            sign  <= 1'b0;
            dcnt  <= '0;
        end else begin
            sync1 <= bus.current_cmp;
            sync2 <= sync1;
            if (sync2 == sign) begin
                dcnt <= '0;
            end else if (dcnt == DEB_LAST) begin
                sign <= ~sign;
                dcnt <= '0;
            end else begin
                dcnt <= dcnt + CW'(1);
            end
        end
    end

    assign bus.DesiredLoad  = dl;
    assign bus.CurrentSign  = sign;
    assign bus.period_start = ps;
    assign bus.duty_err     = err;
    assign bus.running      = (state == ST_RUN);
endmodule

// File: tb/tb_mc_load_sequencer.sv
module tb_mc_load_sequencer;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   tests  = 0;
    int   failed = 0;

    mc_load_sequencer_if #(.PW(10)) bus();

    mc_load_sequencer #(.PW(10), .MIN_DWELL(12), .DEB(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_load(input int a, input int b, input int p);
        bus.duty_a    = 10'(a);
        bus.duty_b    = 10'(b);
        bus.period    = 10'(p);
        bus.duty_load = 1'b1;
        @(negedge clk);
        bus.duty_load = 1'b0;
    endtask

    // Advances to the next negedge that sees period_start (bounded).
    task automatic wait_ps();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.period_start && n < 300);
    endtask

    // Called at a period_start negedge (counter 0); counts the DesiredLoad
    // codes shown for counter values 0..P-1 and returns at the next one.
    task automatic measure(output int na, output int nb, output int nc, output int len);
        na = 0; nb = 0; nc = 0; len = 0;
        do begin
            @(negedge clk);
            len++;
            case (bus.DesiredLoad)
                2'b01:   na++;
                2'b10:   nb++;
                2'b11:   nc++;
                default: ;
            endcase
        end while (!bus.period_start && len < 400);
    endtask

    task automatic test_reset();
        step(2);
        tests++; if (bus.DesiredLoad !== 2'b00) begin failed++; $display("FAIL reset_dl got=%b exp=00", bus.DesiredLoad); end
        tests++; if (bus.running !== 1'b0) begin failed++; $display("FAIL reset_running got=%b exp=0", bus.running); end
        tests++; if (bus.period_start !== 1'b0) begin failed++; $display("FAIL reset_ps got=%b exp=0", bus.period_start); end
        tests++; if (bus.duty_err !== 1'b0) begin failed++; $display("FAIL reset_err got=%b exp=0", bus.duty_err); end
        tests++; if (bus.CurrentSign !== 1'b0) begin failed++; $display("FAIL reset_sign got=%b exp=0", bus.CurrentSign); end
        rst = 1'b1;
        step(1);
    endtask

    task automatic test_basic();
        int na, nb, nc, len;
        pulse_load(30, 40, 100);
        bus.enable = 1'b1;
        wait_ps();
        tests++; if (bus.running !== 1'b1) begin failed++; $display("FAIL basic_running got=%b exp=1", bus.running); end
        tests++; if (bus.DesiredLoad !== 2'b00) begin failed++; $display("FAIL basic_first_dl got=%b exp=00", bus.DesiredLoad); end
        measure(na, nb, nc, len);
        tests++; if (na !== 30) begin failed++; $display("FAIL basic_a got=%0d exp=30", na); end
        tests++; if (nb !== 40) begin failed++; $display("FAIL basic_b got=%0d exp=40", nb); end
        tests++; if (nc !== 30) begin failed++; $display("FAIL basic_c got=%0d exp=30", nc); end
        tests++; if (len !== 100) begin failed++; $display("FAIL basic_len got=%0d exp=100", len); end
        measure(na, nb, nc, len);
        tests++; if (len !== 100 || na !== 30) begin failed++; $display("FAIL basic_repeat got len=%0d a=%0d exp len=100 a=30", len, na); end
    endtask

    task automatic test_bad_load();
        int na, nb, nc, len;
        step(10);
        pulse_load(60, 50, 100);
        tests++; if (bus.duty_err !== 1'b1) begin failed++; $display("FAIL badload_err got=%b exp=1", bus.duty_err); end
        wait_ps();
        measure(na, nb, nc, len);
        tests++; if (na !== 30 || nb !== 40 || nc !== 30) begin failed++; $display("FAIL badload_old got=%0d/%0d/%0d exp=30/40/30", na, nb, nc); end
        step(5);
        pulse_load(0, 0, 11);
        tests++; if (bus.duty_err !== 1'b1) begin failed++; $display("FAIL shortperiod_err got=%b exp=1", bus.duty_err); end
        pulse_load(50, 50, 100);
        tests++; if (bus.duty_err !== 1'b0) begin failed++; $display("FAIL goodload_err got=%b exp=0", bus.duty_err); end
        wait_ps();
        measure(na, nb, nc, len);
        tests++; if (na !== 50 || nb !== 50 || nc !== 0 || len !== 100) begin failed++; $display("FAIL goodload got=%0d/%0d/%0d len=%0d exp=50/50/0 len=100", na, nb, nc, len); end
    endtask

    task automatic test_clip_remainder();
        int na, nb, nc, len;
        pulse_load(5, 80, 100);
        wait_ps();
        measure(na, nb, nc, len);
        tests++; if (na !== 0 || nb !== 80 || nc !== 20) begin failed++; $display("FAIL clip_a got=%0d/%0d/%0d exp=0/80/20", na, nb, nc); end
        pulse_load(0, 93, 100);
        wait_ps();
        measure(na, nb, nc, len);
        tests++; if (na !== 0 || nb !== 100 || nc !== 0) begin failed++; $display("FAIL rem_to_b got=%0d/%0d/%0d exp=0/100/0", na, nb, nc); end
        pulse_load(95, 0, 100);
        wait_ps();
        measure(na, nb, nc, len);
        tests++; if (na !== 100 || nb !== 0 || nc !== 0) begin failed++; $display("FAIL rem_to_a got=%0d/%0d/%0d exp=100/0/0", na, nb, nc); end
        pulse_load(12, 76, 100);
        wait_ps();
        measure(na, nb, nc, len);
        tests++; if (na !== 12 || nb !== 76 || nc !== 12) begin failed++; $display("FAIL min_dwell_edge got=%0d/%0d/%0d exp=12/76/12", na, nb, nc); end
    endtask

    task automatic test_fault();
        int na, nb, nc, len;
        step(45);
        bus.fault     = 1'b1;
        bus.duty_a    = 10'd60;
        bus.duty_b    = 10'd60;
        bus.period    = 10'd100;
        bus.duty_load = 1'b1;
        step(1);
        bus.fault     = 1'b0;
        bus.duty_load = 1'b0;
        tests++; if (bus.DesiredLoad !== 2'b00) begin failed++; $display("FAIL fault_dl got=%b exp=00", bus.DesiredLoad); end
        tests++; if (bus.running !== 1'b0) begin failed++; $display("FAIL fault_running got=%b exp=0", bus.running); end
        tests++; if (bus.duty_err !== 1'b0) begin failed++; $display("FAIL fault_prio_err got=%b exp=0", bus.duty_err); end
        step(1);
        tests++; if (bus.period_start !== 1'b1 || bus.running !== 1'b1) begin failed++; $display("FAIL fault_restart got ps=%b run=%b exp 1/1", bus.period_start, bus.running); end
        measure(na, nb, nc, len);
        tests++; if (na !== 12 || nb !== 76 || nc !== 12 || len !== 100) begin failed++; $display("FAIL fault_retained got=%0d/%0d/%0d len=%0d exp=12/76/12 len=100", na, nb, nc, len); end
    endtask

    task automatic test_back_to_back();
        int na, nb, nc, len;
        step(10);
        pulse_load(40, 40, 100);
        step(88);
        bus.duty_a    = 10'd20;
        bus.duty_b    = 10'd30;
        bus.period    = 10'd100;
        bus.duty_load = 1'b1;
        step(1);
        bus.duty_load = 1'b0;
        tests++; if (bus.period_start !== 1'b1) begin failed++; $display("FAIL b2b_boundary_ps got=%b exp=1", bus.period_start); end
        measure(na, nb, nc, len);
        tests++; if (na !== 40 || nb !== 40 || nc !== 20) begin failed++; $display("FAIL b2b_old_pending got=%0d/%0d/%0d exp=40/40/20", na, nb, nc); end
        measure(na, nb, nc, len);
        tests++; if (na !== 20 || nb !== 30 || nc !== 50) begin failed++; $display("FAIL b2b_new_pending got=%0d/%0d/%0d exp=20/30/50", na, nb, nc); end
    endtask

    task automatic test_enable_drop();
        step(20);
        bus.enable = 1'b0;
        step(79);
        tests++; if (bus.running !== 1'b1 || bus.DesiredLoad !== 2'b11) begin failed++; $display("FAIL endrop_complete got run=%b dl=%b exp 1/11", bus.running, bus.DesiredLoad); end
        step(1);
        tests++; if (bus.running !== 1'b0 || bus.DesiredLoad !== 2'b00 || bus.period_start !== 1'b0) begin failed++; $display("FAIL endrop_idle got run=%b dl=%b ps=%b exp 0/00/0", bus.running, bus.DesiredLoad, bus.period_start); end
        step(5);
        tests++; if (bus.running !== 1'b0 || bus.DesiredLoad !== 2'b00) begin failed++; $display("FAIL endrop_stay got run=%b dl=%b exp 0/00", bus.running, bus.DesiredLoad); end
    endtask

    task automatic test_sign();
        bus.current_cmp = 1'b1;
        step(5);
        tests++; if (bus.CurrentSign !== 1'b0) begin failed++; $display("FAIL sign_early got=%b exp=0", bus.CurrentSign); end
        step(1);
        tests++; if (bus.CurrentSign !== 1'b1) begin failed++; $display("FAIL sign_latency got=%b exp=1", bus.CurrentSign); end
        bus.current_cmp = 1'b0;
        step(3);
        bus.current_cmp = 1'b1;
        step(10);
        tests++; if (bus.CurrentSign !== 1'b1) begin failed++; $display("FAIL sign_glitch got=%b exp=1", bus.CurrentSign); end
    endtask

    task automatic test_async_reset();
        pulse_load(60, 60, 100);
        tests++; if (bus.duty_err !== 1'b1) begin failed++; $display("FAIL prereset_err got=%b exp=1", bus.duty_err); end
        bus.enable = 1'b1;
        wait_ps();
        step(20);
        tests++; if (bus.DesiredLoad !== 2'b01 || bus.running !== 1'b1) begin failed++; $display("FAIL prereset_run got dl=%b run=%b exp 01/1", bus.DesiredLoad, bus.running); end
        #2;
        rst = 1'b0;
        #1;
        tests++; if (bus.DesiredLoad !== 2'b00) begin failed++; $display("FAIL arst_dl got=%b exp=00", bus.DesiredLoad); end
        tests++; if (bus.running !== 1'b0) begin failed++; $display("FAIL arst_running got=%b exp=0", bus.running); end
        tests++; if (bus.duty_err !== 1'b0) begin failed++; $display("FAIL arst_err got=%b exp=0", bus.duty_err); end
        tests++; if (bus.CurrentSign !== 1'b0) begin failed++; $display("FAIL arst_sign got=%b exp=0", bus.CurrentSign); end
        step(2);
        rst = 1'b1;
        step(1);
    endtask

    initial begin
        bus.enable      = 1'b0;
        bus.fault       = 1'b0;
        bus.duty_load   = 1'b0;
        bus.duty_a      = '0;
        bus.duty_b      = '0;
        bus.period      = '0;
        bus.current_cmp = 1'b0;
        test_reset();
        test_basic();
        test_bad_load();
        test_clip_remainder();
        test_fault();
        test_back_to_back();
        test_enable_drop();
        test_sign();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
